// File: rtl/blk_rr_sched_if.sv
// Channel-FIFO side and output side of the round-robin block scheduler.
// The scheduler takes the master modport; FIFO/sink models take the slave modport.
interface blk_rr_sched_if #(
  parameter int NCH = 17
) ();
  logic [NCH-1:0]    fifo_have;
  logic [16*NCH-1:0] datain;
  logic [NCH-1:0]    ch_mask;
  logic [NCH-1:0]    arb_want;
  logic [15:0]       dataout;
  logic              kchar;
  logic              busy;
  logic              err_fmt;
  logic              err_tmo;

  modport master (
    input  fifo_have, datain, ch_mask,
    output arb_want, dataout, kchar, busy, err_fmt, err_tmo
  );

  modport slave (
    output fifo_have, datain, ch_mask,
    input  arb_want, dataout, kchar, busy, err_fmt, err_tmo
  );
endinterface

// File: rtl/blk_rr_sched.sv
// Round-robin block scheduler: picks the next channel holding a block header,
// streams the whole block to a single output, and inserts KIDLE when starved.
module blk_rr_sched #(
  parameter int          NCH   = 17,
  parameter int          TMO   = 1023,
  parameter logic [15:0] KIDLE = 16'h50BC
) (
  input logic            clk,
  input logic            rst_n,
  blk_rr_sched_if.master bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  sel, sel_nxt, last, last_nxt, start;
  logic [8:0]     wcnt, wcnt_nxt;
  logic [9:0]     wdog, wdog_nxt;
  logic [NCH-1:0] want, want_nxt, hdr_ok, bad_ok;
  logic [15:0]    dout, dout_nxt, word;
  logic           kchar_q, kchar_nxt, busy_q, busy_nxt;
  logic           efmt_q, efmt_nxt, etmo_q, etmo_nxt;
  logic           blk_end;
  logic [CW:0]    hdr_pick, bad_pick;
  logic [15:0]    head [NCH];

  function automatic logic [NCH-1:0] onehot(input logic [CW-1:0] idx);
    logic [NCH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Returns {found, index} of the first set bit at or after st, wrapping to 0.
  function automatic logic [CW:0] rr_pick(input logic [NCH-1:0] ok, input logic [CW-1:0] st);
    logic          found;
    logic [CW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && ok[i] && (CW'(i) >= st)) begin
        found = 1'b1;
        idx   = CW'(i);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!found && ok[i] && (CW'(i) < st)) begin
        found = 1'b1;
        idx   = CW'(i);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      head[i]   = bus.datain[16*i +: 16];
      hdr_ok[i] = bus.fifo_have[i] & bus.ch_mask[i] & head[i][15];
      bad_ok[i] = bus.fifo_have[i] & bus.ch_mask[i] & ~head[i][15];
    end
  end

  assign start    = (last == CW'(NCH - 1)) ? '0 : last + 1'b1;
  assign hdr_pick = rr_pick(hdr_ok, start);
  assign bad_pick = rr_pick(bad_ok, start);

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    last_nxt  = last;
    wcnt_nxt  = wcnt;
    wdog_nxt  = wdog;
    want_nxt  = '0;
    dout_nxt  = KIDLE;
    kchar_nxt = 1'b1;
    efmt_nxt  = 1'b0;
    etmo_nxt  = 1'b0;
    blk_end   = 1'b0;
    word      = head[sel];
    case (state)
      IDLE: begin
        // A non-zero strobe here is a discard in flight; let it land before rescanning.
        if (want == '0) begin
          if (hdr_pick[CW]) begin
            state_nxt = XFER;
            sel_nxt   = hdr_pick[CW-1:0];
            want_nxt  = onehot(hdr_pick[CW-1:0]);
            wcnt_nxt  = '0;
            wdog_nxt  = '0;
          end else if (bad_pick[CW]) begin
            want_nxt = onehot(bad_pick[CW-1:0]);
            efmt_nxt = 1'b1;
          end
        end
      end
      XFER: begin
        want_nxt = want;
        if (bus.fifo_have[sel]) begin
          dout_nxt  = word;
          kchar_nxt = 1'b0;
          wdog_nxt  = '0;
          // wcnt == 0 marks that the header has not been taken yet.
          if (wcnt == 9'd0) begin
            if (word[8:0] < 9'd2) begin
              efmt_nxt = 1'b1;
              blk_end  = 1'b1;
            end else begin
              wcnt_nxt = word[8:0] - 9'd1;
            end
          end else begin
            efmt_nxt = word[15];
            blk_end  = (wcnt == 9'd1);
            wcnt_nxt = wcnt - 9'd1;
          end
        end else if (wdog == 10'(TMO - 1)) begin
          etmo_nxt = 1'b1;
          blk_end  = 1'b1;
        end else begin
          wdog_nxt = wdog + 10'd1;
        end
        if (blk_end) begin
          state_nxt = IDLE;
          want_nxt  = '0;
          last_nxt  = sel;
          wcnt_nxt  = '0;
          wdog_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Busy spans the strobe cycle through the cycle the final word sits on dataout.
    busy_nxt = (state_nxt == XFER) || (state == XFER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      last    <= CW'(NCH - 1);
      wcnt    <= '0;
      wdog    <= '0;
      want    <= '0;
      dout    <= KIDLE;
      kchar_q <= 1'b1;
      busy_q  <= 1'b0;
      efmt_q  <= 1'b0;
      etmo_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      last    <= last_nxt;
      wcnt    <= wcnt_nxt;
      wdog    <= wdog_nxt;
      want    <= want_nxt;
      dout    <= dout_nxt;
      kchar_q <= kchar_nxt;
      busy_q  <= busy_nxt;
      efmt_q  <= efmt_nxt;
      etmo_q  <= etmo_nxt;
    end
  end

  assign bus.arb_want = want;
  assign bus.dataout  = dout;
  assign bus.kchar    = kchar_q;
  assign bus.busy     = busy_q;
  assign bus.err_fmt  = efmt_q;
  assign bus.err_tmo  = etmo_q;
endmodule

// File: tb/tb_blk_rr_sched.sv
// Bench for blk_rr_sched: directed scenarios plus randomized block traffic
// compared against a transaction-level round-robin model of per-channel FIFOs.
module tb_blk_rr_sched;
  localparam int          NCH = 17;
  localparam int          TMO = 40;
  localparam logic [15:0] K   = 16'h50BC;

  logic clk;
  logic rst_n;

  blk_rr_sched_if #(.NCH(NCH)) bus ();

  blk_rr_sched #(.NCH(NCH), .TMO(TMO), .KIDLE(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int             total = 0;
  int             bad   = 0;
  int             nb, ch, len;
  logic [15:0]    q [NCH][$];
  logic [15:0]    exp_q [$];
  logic [15:0]    got_q [$];
  logic [NCH-1:0] hold;
  bit             seen_fmt, seen_tmo;
  logic [15:0]    ed [10];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present each channel's FIFO head; a held channel shows fifo_have low.
  task automatic drive();
    logic [NCH-1:0]    fh;
    logic [16*NCH-1:0] din;
    fh  = '0;
    din = '0;
    for (int i = 0; i < NCH; i++) begin
      if (q[i].size() > 0) begin
        fh[i]            = ~hold[i];
        din[16*i +: 16]  = q[i][0];
      end
    end
    bus.fifo_have = fh;
    bus.datain    = din;
  endtask

  // One clock; a word leaves its FIFO when strobe and have were both high before the edge.
  task automatic tick();
    logic [NCH-1:0] aw, fh;
    aw = bus.arb_want;
    fh = bus.fifo_have;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++)
      if (aw[i] && fh[i] && q[i].size() > 0) void'(q[i].pop_front());
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NCH; i++) if (q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic do_reset();
    rst_n        = 1'b0;
    hold         = '0;
    bus.ch_mask  = '1;
    for (int i = 0; i < NCH; i++) q[i].delete();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Expected output word order: serve whole blocks, next non-empty channel after the last one served.
  task automatic build_expect();
    logic [15:0] m [NCH][$];
    int          last, pick, c, l;
    exp_q.delete();
    for (int i = 0; i < NCH; i++) m[i] = q[i];
    last = NCH - 1;
    do begin
      pick = -1;
      for (int k = 1; k <= NCH; k++) begin
        c = (last + k) % NCH;
        if (pick < 0 && m[c].size() > 0) pick = c;
      end
      if (pick >= 0) begin
        l = int'(m[pick][0][8:0]);
        for (int w = 0; w < l && m[pick].size() > 0; w++) exp_q.push_back(m[pick].pop_front());
        last = pick;
      end
    end while (pick >= 0);
  endtask

  task automatic run_stream(input int maxc, input bit stall);
    int n, run;
    bit done;
    got_q.delete();
    n = 0; run = 0; done = 1'b0; seen_fmt = 1'b0; seen_tmo = 1'b0;
    while (!done && n < maxc) begin
      hold = '0;
      if (stall && bus.arb_want != '0 && run < 8 && $urandom_range(0, 3) == 0) begin
        hold = bus.arb_want;
        run++;
      end else begin
        run = 0;
      end
      drive();
      tick();
      n++;
      if (!bus.kchar) got_q.push_back(bus.dataout);
      if (bus.err_fmt) seen_fmt = 1'b1;
      if (bus.err_tmo) seen_tmo = 1'b1;
      if (all_empty() && bus.arb_want == '0 && !bus.busy) done = 1'b1;
    end
    hold = '0;
    chk("stream_done", 32'(done), 1);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    rst_n         = 1'b0;
    hold          = '0;
    bus.ch_mask   = '1;
    bus.fifo_have = '0;
    bus.datain    = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_arb_want", 32'(bus.arb_want), 0);
    chk("rst_dataout", 32'(bus.dataout), 32'(K));
    chk("rst_kchar", 32'(bus.kchar), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err_fmt", 32'(bus.err_fmt), 0);
    chk("rst_err_tmo", 32'(bus.err_tmo), 0);
    rst_n = 1'b1;

    // Single channel 3, L=4, steady FIFO.
    do_reset();
    q[3] = '{16'h8004, 16'h0011, 16'h0022, 16'h0033};
    ed   = '{K, 16'h8004, 16'h0011, 16'h0022, 16'h0033, K, K, K, K, K};
    nb   = 0;
    for (int e = 1; e <= 6; e++) begin
      drive();
      tick();
      if (bus.busy) nb++;
      chk($sformatf("b_dout%0d", e), 32'(bus.dataout), 32'(ed[e-1]));
      chk($sformatf("b_kchar%0d", e), 32'(bus.kchar), (e >= 2 && e <= 5) ? 1'b0 : 1'b1);
      chk($sformatf("b_aw%0d", e), 32'(bus.arb_want), (e <= 4) ? 8 : 0);
    end
    chk("b_busy_cycles", nb, 5);

    // Channels 0, 5, 16 each with three L=2 blocks.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      q[0].push_back(16'h8002);  q[0].push_back(16'(r));
      q[5].push_back(16'h8002);  q[5].push_back(16'(16'h0500 + r));
      q[16].push_back(16'h8002); q[16].push_back(16'(16'h1000 + r));
    end
    build_expect();
    run_stream(300, 1'b0);
    cmp_stream("c");
    chk("c_order0", 32'(got_q[1]), 'h0000);
    chk("c_order1", 32'(got_q[3]), 'h0500);
    chk("c_order2", 32'(got_q[5]), 'h1000);
    chk("c_order3", 32'(got_q[7]), 'h0001);
    chk("c_no_fmt", 32'(seen_fmt), 0);

    // Channel 7, L=5, FIFO empty for three cycles after the second word.
    do_reset();
    q[7]     = '{16'h8005, 16'h0701, 16'h0702, 16'h0703, 16'h0704};
    ed       = '{K, 16'h8005, 16'h0701, K, K, K, 16'h0702, 16'h0703, 16'h0704, K};
    seen_tmo = 1'b0;
    for (int c = 0; c < 10; c++) begin
      hold[7] = (c >= 3 && c <= 5);
      drive();
      tick();
      if (bus.err_tmo) seen_tmo = 1'b1;
      chk($sformatf("d_dout%0d", c + 1), 32'(bus.dataout), 32'(ed[c]));
      chk($sformatf("d_kchar%0d", c + 1), 32'(bus.kchar), (ed[c] == K) ? 1 : 0);
    end
    hold = '0;
    chk("d_no_tmo", 32'(seen_tmo), 0);
    chk("d_drained", q[7].size(), 0);

    // Channel 2 stalls after its header until the watchdog fires; channel 6 follows.
    do_reset();
    q[2].push_back(16'h800A);
    for (int w = 1; w < 10; w++) q[2].push_back(16'(16'h0200 + w));
    q[6] = '{16'h8002, 16'h0601};
    for (int c = 0; c < TMO + 4; c++) begin
      hold[2] = (c >= 2);
      drive();
      tick();
      chk($sformatf("e_tmo%0d", c + 1), 32'(bus.err_tmo), (c + 1 == TMO + 2) ? 1 : 0);
      if (c + 1 == 1)       chk("e_sel_ch2", 32'(bus.arb_want), 'h4);
      if (c + 1 == TMO + 2) chk("e_aw_drop", 32'(bus.arb_want), 0);
      if (c + 1 == TMO + 3) chk("e_next_ch6", 32'(bus.arb_want), 'h40);
      if (c + 1 == TMO + 4) chk("e_ch6_hdr", 32'(bus.dataout), 'h8002);
    end
    hold = '0;
    chk("e_left_in_fifo", q[2].size(), 9);

    // Channel 1 has a stray data word, channel 4 a header with L=1.
    do_reset();
    q[1] = '{16'h0012};
    q[4] = '{16'h8001};
    for (int c = 0; c < 5; c++) begin
      drive();
      tick();
      chk($sformatf("f_aw%0d", c + 1), 32'(bus.arb_want), (c == 0) ? 'h10 : ((c == 2) ? 'h2 : 0));
      chk($sformatf("f_fmt%0d", c + 1), 32'(bus.err_fmt), (c == 1 || c == 2) ? 1 : 0);
      chk($sformatf("f_dout%0d", c + 1), 32'(bus.dataout), (c == 1) ? 'h8001 : 32'(K));
    end
    chk("f_ch1_discarded", q[1].size(), 0);
    chk("f_ch4_drained", q[4].size(), 0);

    // Reset asserted mid-block on channel 9; scan restarts from channel 0.
    do_reset();
    q[9] = '{16'h8008, 16'h0901, 16'h0902, 16'h0903, 16'h0904, 16'h0905, 16'h0906, 16'h0907};
    for (int c = 0; c < 4; c++) begin
      drive();
      tick();
    end
    chk("g_word3", 32'(bus.dataout), 'h0902);
    rst_n = 1'b0;
    #1;
    chk("g_rst_aw", 32'(bus.arb_want), 0);
    chk("g_rst_dout", 32'(bus.dataout), 32'(K));
    chk("g_rst_kchar", 32'(bus.kchar), 1);
    chk("g_rst_busy", 32'(bus.busy), 0);
    chk("g_rst_fmt", 32'(bus.err_fmt), 0);
    chk("g_rst_tmo", 32'(bus.err_tmo), 0);
    q[0]  = '{16'h8002, 16'h0001};
    q[12] = '{16'h8002, 16'h0C01};
    drive();
    tick();
    tick();
    rst_n = 1'b1;
    drive();
    tick();
    chk("g_first_ch0", 32'(bus.arb_want), 'h1);
    chk("g_no_fmt", 32'(bus.err_fmt), 0);

    // Randomized blocks on random channels with random starvation mid-block.
    do_reset();
    for (int b = 0; b < 14; b++) begin
      ch  = int'($urandom_range(0, NCH - 1));
      len = int'($urandom_range(2, 6));
      q[ch].push_back(16'(16'h8000 + len));
      for (int w = 1; w < len; w++) q[ch].push_back(16'($urandom_range(0, 'h7FFF)));
    end
    build_expect();
    run_stream(2000, 1'b1);
    cmp_stream("h");
    chk("h_no_fmt", 32'(seen_fmt), 0);
    chk("h_no_tmo", 32'(seen_tmo), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
